vga_fb_arbiter: RTL and testbench
=================================

// Module: vga_fb_arbiter
// PURPOSE
// Shares one single-port synchronous frame-buffer RAM between the display fetch
// path and a pixel-writer port. It sits beside the VGA sync generator, taking its
// xpos/ypos/disp_active, and returns pixel data aligned to the active display.
// Display fetch always wins the RAM. Writes are buffered in a small FIFO and
// drained in blanking cycles, or in any cycle while the display is not running.
// PARAMETERS
// H_ACTIVE    800  visible pixels per line (must equal sync generator 'a')
// V_ACTIVE    600  visible lines per frame (must equal sync generator 'b')
// ADDR_W      19   frame-buffer address width; must hold H_ACTIVE*V_ACTIVE-1
// DATA_W      8    pixel width
// FIFO_DEPTH  4    write FIFO entries (power of two, >=2)
// PORTS
// clock        in   1       pixel clock, same clock as the sync generator
// reset        in   1       asynchronous, active-high
// xpos         in   11      horizontal position from the sync generator
// ypos         in   11      vertical position from the sync generator
// disp_active  in   1       registered active flag from the sync generator (1 cycle after xpos/ypos)
// display_en   in   1       1 = fetch and display the frame buffer; 0 = blank output
// wr_valid     in   1       writer request valid
// wr_ready     out  1       FIFO can accept; a push happens when wr_valid & wr_ready
// wr_addr      in   ADDR_W  writer pixel address
// wr_data      in   DATA_W  writer pixel value
// mem_addr     out  ADDR_W  RAM address (combinational)
// mem_we       out  1       RAM write enable (combinational)
// mem_wdata    out  DATA_W  RAM write data
// mem_rdata    in   DATA_W  RAM read data, valid 1 cycle after mem_addr
// pix_data     out  DATA_W  pixel to DAC, registered
// pix_valid    out  1       pix_data holds a fetched pixel
// fifo_level   out  3       entries in the write FIFO (width clog2(FIFO_DEPTH)+1)
// BEHAVIOUR
// Reset values: state=S_WAIT, fetch_addr=0, FIFO empty, pix_data=0, pix_valid=0,
// wr_ready=1, fifo_level=0.
// FSM:
// - S_WAIT: no fetch. Go to S_RUN on the first cycle with display_en=1 and
//   ypos>=V_ACTIVE (vertical blank), so display never starts mid-frame.
// - S_RUN: go to S_WAIT on the cycle after display_en is sampled low. No frame
//   tearing is compensated; re-enable waits for the next vertical blank.
// fetch_slot = (state==S_RUN) & xpos<H_ACTIVE & ypos<V_ACTIVE.
// Address generation:
// - fetch_slot: mem_addr=fetch_addr, mem_we=0, and fetch_addr increments.
// - fetch_addr clears to 0 whenever ypos>=V_ACTIVE or state==S_WAIT.
// - No multiplier: the address is a linear count, row-major.
// Write drain:
// - When !fetch_slot and the FIFO is non-empty: mem_addr/mem_wdata = head entry,
//   mem_we=1, and the head is popped the same cycle.
// - Otherwise mem_we=0, and mem_addr holds fetch_addr (no-op read).
// FIFO:
// - wr_ready = (fifo_level < FIFO_DEPTH).
// - Push and pop in the same cycle leave the level unchanged. When full, no push.
// - Writes commit to RAM in push order.
// Output pipeline, 2 cycles from the xpos/ypos sample to the pixel:
// - Cycle t: fetch address presented.
// - Cycle t+1: mem_rdata is valid and disp_active is high.
// - Cycle t+2: pix_data <= disp_active & d_fetch ? mem_rdata : 0,
//   where d_fetch is fetch_slot delayed 1 cycle.
// - pix_valid is the same condition, registered.
// Read-after-write hazard: a write and a fetch to the same address are never
// simultaneous. Fetch reads whatever the RAM holds; tearing is software's concern.
// Reset mid-frame: outputs clear immediately. The block returns to S_WAIT and
// resumes at the next vertical blank. FIFO contents are discarded.
// TESTING
// Bench setup: H_ACTIVE=8, V_ACTIVE=4, x_total=12, y_total=6. RAM model has
// 1-cycle latency and is preloaded with mem[i]=i.
// 1. Reset released mid-frame at ypos=1 with display_en=1 -> no fetch until
//    ypos=4. On the next frame, pix_data sequence = 0..31 and pix_valid is high
//    for 32 cycles, each 2 cycles after its xpos.
// 2. display_en=1, then 5 back-to-back wr_valid during active line 0 ->
//    wr_ready drops after 4 pushes. First mem_we occurs at xpos=8 (blanking),
//    one write per cycle, and fifo_level returns to 0 within 5 blank cycles.
// 3. Write addr=3 data=0xAA during frame N blank -> frame N+1 pix_data at
//    pixel 3 = 0xAA.
// 4. display_en dropped at ypos=2 -> pix_valid=0 from 2 cycles later, and
//    writes drain during active cycles. Re-enable at ypos=2 -> output resumes
//    only at the ypos=0 after vertical blank, starting with pixel 0.
// 5. Simultaneous push and pop with fifo_level=2 -> level stays 2, and the
//    order of writes in RAM matches push order.
// 6. Assert reset during a write burst -> mem_we=0 at once, fifo_level=0, and
//    no stale write appears after release.

Source files
------------

// File: rtl/vga_fb_arbiter_if.sv
// Writer port and frame-buffer RAM port of the arbiter, bundled as one bus.
// The master side is the arbiter: it owns the RAM controls and wr_ready.
// The slave side is the environment: pixel writer and RAM model.
interface vga_fb_arbiter_if #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 8
);
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    input  wr_valid, wr_addr, wr_data, mem_rdata,
    output wr_ready, mem_addr, mem_we, mem_wdata
  );

  modport slave (
    output wr_valid, wr_addr, wr_data, mem_rdata,
    input  wr_ready, mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/vga_fb_arbiter.sv
// Single-port frame-buffer arbiter. Display fetch owns the RAM during active
// pixels; buffered writer requests drain in every other cycle. Pixels come out
// two cycles after the xpos/ypos they belong to.
module vga_fb_arbiter #(
  parameter int H_ACTIVE   = 800,
  parameter int V_ACTIVE   = 600,
  parameter int ADDR_W     = 19,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [10:0]                   xpos,
  input  logic [10:0]                   ypos,
  input  logic                          disp_active,
  input  logic                          display_en,
  vga_fb_arbiter_if.master              bus,
  output logic [DATA_W-1:0]             pix_data,
  output logic                          pix_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [10:0]    H_LIM   = 11'(H_ACTIVE);
  localparam logic [10:0]    V_LIM   = 11'(V_ACTIVE);
  localparam logic [PTR_W:0] LVL_MAX = (PTR_W+1)'(FIFO_DEPTH);

  typedef enum logic {S_WAIT, S_RUN} state_t;

  state_t            state;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_slot;
  logic              d_fetch;
  logic              push, pop;
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [ADDR_W-1:0] q_addr [FIFO_DEPTH];
  logic [DATA_W-1:0] q_data [FIFO_DEPTH];

  assign fetch_slot   = (state == S_RUN) && (xpos < H_LIM) && (ypos < V_LIM);
  assign bus.wr_ready = (fifo_level < LVL_MAX);
  assign push         = bus.wr_valid && bus.wr_ready;
  // A freshly pushed entry is not visible until the next cycle, so pop only
  // ever sees entries already stored.
  assign pop          = !fetch_slot && (fifo_level != '0);

  // RAM port mux: fetch has priority, otherwise the FIFO head is written.
  // An idle cycle leaves fetch_addr on the bus as a harmless read.
  assign bus.mem_we    = pop;
  assign bus.mem_addr  = pop ? q_addr[rd_ptr] : fetch_addr;
  assign bus.mem_wdata = q_data[rd_ptr];

  // Display FSM and linear fetch address; start only in vertical blank so a
  // frame is never joined half-way through.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= S_WAIT;
      fetch_addr <= '0;
    end else begin
      case (state)
        S_WAIT: if (display_en && ypos >= V_LIM) state <= S_RUN;
        S_RUN:  if (!display_en) state <= S_WAIT;
        default: state <= S_WAIT;
      endcase
      if (state == S_WAIT || ypos >= V_LIM) fetch_addr <= '0;
      else if (fetch_slot)                 fetch_addr <= fetch_addr + ADDR_W'(1);
    end
  end

  // FIFO pointers and occupancy; reset discards any pending writes.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // FIFO storage; contents are meaningless once the pointers are reset.
  always_ff @(posedge clock) begin
    if (push) begin
      q_addr[wr_ptr] <= bus.wr_addr;
      q_data[wr_ptr] <= bus.wr_data;
    end
  end

  // Output pipeline: d_fetch lines the fetch flag up with mem_rdata and the
  // sync generator's registered disp_active.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      d_fetch   <= 1'b0;
      pix_data  <= '0;
      pix_valid <= 1'b0;
    end else begin
      d_fetch   <= fetch_slot;
      pix_valid <= disp_active && d_fetch;
      pix_data  <= (disp_active && d_fetch) ? bus.mem_rdata : '0;
    end
  end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter on a shrunk 8x4 display (12x6 totals).
module tb_vga_fb_arbiter;
  logic        clock = 1'b0;
  logic        reset;
  logic        display_en;
  logic [10:0] xpos = '0;
  logic [10:0] ypos = '0;
  logic        disp_active = 1'b0;
  logic [7:0]  pix_data;
  logic        pix_valid;
  logic [2:0]  fifo_level;
  logic [7:0]  ram [32];

  int checks = 0;
  int errors = 0;
  int cnt, nvalid, hx1, hy1, hx2, hy2;
  bit ev;

  vga_fb_arbiter_if #(.ADDR_W(5), .DATA_W(8)) mif ();

  vga_fb_arbiter #(
    .H_ACTIVE(8), .V_ACTIVE(4), .ADDR_W(5), .DATA_W(8), .FIFO_DEPTH(4)
  ) dut (
    .clock(clock), .reset(reset), .xpos(xpos), .ypos(ypos),
    .disp_active(disp_active), .display_en(display_en), .bus(mif.master),
    .pix_data(pix_data), .pix_valid(pix_valid), .fifo_level(fifo_level)
  );

  always #5 clock = ~clock;

  // Sync generator model: free running, never reset with the DUT.
  always @(posedge clock) begin
    if (xpos == 11'd11) begin
      xpos <= '0;
      ypos <= (ypos == 11'd5) ? 11'd0 : ypos + 11'd1;
    end else begin
      xpos <= xpos + 11'd1;
    end
    disp_active <= (xpos < 11'd8) && (ypos < 11'd4);
  end

  // 1-cycle latency RAM, preloaded with mem[i]=i.
  initial for (int i = 0; i < 32; i++) ram[i] = 8'(i);
  always @(posedge clock) begin
    if (mif.mem_we) ram[mif.mem_addr] <= mif.mem_wdata;
    mif.mem_rdata <= ram[mif.mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance at least one cycle, then stop at the negedge where (xpos,ypos)=(x,y).
  task automatic wait_xy(input int x, input int y);
    int n;
    n = 0;
    @(negedge clock);
    while (!(xpos == 11'(x) && ypos == 11'(y)) && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $error("FAIL wait_xy: timeout observed (%0d,%0d) expected (%0d,%0d)", xpos, ypos, x, y);
    end
  endtask

  task automatic push(input int a, input int d);
    mif.wr_valid = 1'b1;
    mif.wr_addr  = 5'(a);
    mif.wr_data  = 8'(d);
  endtask

  initial begin
    reset        = 1'b1;
    display_en   = 1'b1;
    mif.wr_valid = 1'b0;
    mif.wr_addr  = '0;
    mif.wr_data  = '0;

    // Reset state
    @(negedge clock);
    chk("rst_pix_valid", pix_valid, 0);
    chk("rst_pix_data", pix_data, 0);
    chk("rst_wr_ready", mif.wr_ready, 1);
    chk("rst_fifo_level", fifo_level, 0);
    chk("rst_mem_we", mif.mem_we, 0);

    // 1. Release mid-frame at ypos=1: nothing until vertical blank
    wait_xy(0, 1);
    reset = 1'b0;
    cnt = 0;
    for (int n = 0; n < 100 && ypos != 11'd4; n++) begin
      cnt += int'(pix_valid);
      @(negedge clock);
    end
    chk("s1_quiet_mid_frame", cnt, 0);
    wait_xy(0, 5);
    hx1 = 11; hy1 = 4; hx2 = 10; hy2 = 4; nvalid = 0;
    for (int n = 0; n < 72; n++) begin
      ev = (hx2 < 8) && (hy2 < 4);
      chk("s1_valid", pix_valid, ev);
      chk("s1_data", pix_data, ev ? hy2 * 8 + hx2 : 0);
      if (ev) nvalid++;
      hx2 = hx1; hy2 = hy1; hx1 = int'(xpos); hy1 = int'(ypos);
      @(negedge clock);
    end
    chk("s1_valid_count", nvalid, 32);

    // 2. Five back-to-back writes in active line 0, drained in blanking
    wait_xy(0, 0);
    push(20, 8'h50);
    chk("s2_ready0", mif.wr_ready, 1);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clock);
      chk("s2_level_fill", fifo_level, i);
      chk("s2_ready", mif.wr_ready, (i < 4) ? 1 : 0);
      chk("s2_no_we_active", mif.mem_we, 0);
      push(20 + i, 8'h50 + i);
    end
    @(negedge clock);
    mif.wr_valid = 1'b0;
    chk("s2_full_no_push", fifo_level, 4);
    chk("s2_no_we_x5", mif.mem_we, 0);
    wait_xy(8, 0);
    for (int j = 0; j < 4; j++) begin
      chk("s2_we", mif.mem_we, 1);
      chk("s2_addr", mif.mem_addr, 20 + j);
      chk("s2_wdata", mif.mem_wdata, 8'h50 + j);
      chk("s2_level_drain", fifo_level, 4 - j);
      @(negedge clock);
    end
    chk("s2_we_line1", mif.mem_we, 0);
    chk("s2_level_empty", fifo_level, 0);

    // 3. Write pixel 3 in blank, see it next frame
    wait_xy(0, 4);
    push(3, 8'hAA);
    @(negedge clock);
    mif.wr_valid = 1'b0;
    chk("s3_we", mif.mem_we, 1);
    chk("s3_addr", mif.mem_addr, 3);
    chk("s3_wdata", mif.mem_wdata, 8'hAA);
    wait_xy(5, 0);
    chk("s3_pix3_valid", pix_valid, 1);
    chk("s3_pix3", pix_data, 8'hAA);
    @(negedge clock);
    chk("s3_pix4", pix_data, 4);

    // 4. Disable at ypos=2, drain during active, re-enable waits for blank
    wait_xy(0, 2);
    display_en = 1'b0;
    @(negedge clock);
    @(negedge clock);
    chk("s4_last_valid", pix_valid, 1);
    chk("s4_last_data", pix_data, 16);
    @(negedge clock);
    chk("s4_off_valid", pix_valid, 0);
    chk("s4_off_data", pix_data, 0);
    @(negedge clock);
    push(30, 8'h77);
    @(negedge clock);
    mif.wr_valid = 1'b0;
    chk("s4_drain_we", mif.mem_we, 1);
    chk("s4_drain_addr", mif.mem_addr, 30);
    @(negedge clock);
    display_en = 1'b1;
    cnt = 0;
    for (int n = 0; n < 100 && !(xpos == 11'd2 && ypos == 11'd0); n++) begin
      cnt += int'(pix_valid);
      @(negedge clock);
    end
    chk("s4_quiet_until_frame", cnt, 0);
    chk("s4_resume_valid", pix_valid, 1);
    chk("s4_resume_pix0", pix_data, 0);
    @(negedge clock);
    chk("s4_resume_pix1", pix_data, 1);

    // 5. Push and pop together at level 2, order preserved
    wait_xy(6, 1);
    push(24, 8'h61);
    @(negedge clock);
    push(25, 8'h62);
    chk("s5_level1", fifo_level, 1);
    @(negedge clock);
    push(26, 8'h63);
    chk("s5_level_x8", fifo_level, 2);
    chk("s5_addr_x8", mif.mem_addr, 24);
    chk("s5_wdata_x8", mif.mem_wdata, 8'h61);
    @(negedge clock);
    push(27, 8'h64);
    chk("s5_level_x9", fifo_level, 2);
    chk("s5_addr_x9", mif.mem_addr, 25);
    @(negedge clock);
    mif.wr_valid = 1'b0;
    chk("s5_level_x10", fifo_level, 2);
    chk("s5_addr_x10", mif.mem_addr, 26);
    @(negedge clock);
    chk("s5_level_x11", fifo_level, 1);
    chk("s5_addr_x11", mif.mem_addr, 27);
    chk("s5_wdata_x11", mif.mem_wdata, 8'h64);
    @(negedge clock);
    chk("s5_level_end", fifo_level, 0);
    chk("s5_we_end", mif.mem_we, 0);

    // 6. Reset in the middle of a drain burst
    wait_xy(5, 2);
    push(28, 8'h71);
    @(negedge clock);
    push(29, 8'h72);
    @(negedge clock);
    push(30, 8'h73);
    @(negedge clock);
    mif.wr_valid = 1'b0;
    chk("s6_we_before", mif.mem_we, 1);
    chk("s6_level_before", fifo_level, 3);
    reset = 1'b1;
    #1;
    chk("s6_we_async", mif.mem_we, 0);
    chk("s6_level_async", fifo_level, 0);
    chk("s6_ready_async", mif.wr_ready, 1);
    chk("s6_pix_valid_async", pix_valid, 0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    cnt = 0;
    for (int n = 0; n < 30; n++) begin
      cnt += int'(mif.mem_we);
      @(negedge clock);
    end
    chk("s6_no_stale_we", cnt, 0);
    chk("s6_ram29_kept", ram[29], 29);
    chk("s6_ram30_kept", ram[30], 8'h77);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
